avl_line_responder: RTL and testbench

AVL_LINE_RESPONDER -- requirements
Module: avl_line_responder

---
 rtl/avl_line_responder.sv | 147 ++++++++++++++
 tb/tb_avl_line_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/avl_line_responder.sv
// Avalon-style line memory responder: single-beat and burst writes with byte enables,
// pipelined burst reads with fixed latency, and periodic stall injection on avl_ready.
module avl_line_responder #(
  parameter int ADDR_WIDTH    = 32,
  parameter int LINE_WIDTH    = 256,
  parameter int MEM_LINES_LOG = 6,
  parameter int READ_LATENCY  = 4,
  parameter int STALL_BURST   = 5,
  parameter int STALL_IDLE    = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    avl_ready,
  input  logic [ADDR_WIDTH-1:0]   avl_addr,
  input  logic [2:0]              avl_size,
  input  logic [LINE_WIDTH-1:0]   avl_wdata,
  input  logic [LINE_WIDTH/8-1:0] avl_be,
  input  logic                    avl_write_req,
  input  logic                    avl_read_req,
  input  logic                    avl_burstbegin,
  output logic [LINE_WIDTH-1:0]   avl_rdata,
  output logic                    avl_rdata_valid
);

  localparam int BE_W  = LINE_WIDTH / 8;
  localparam int LINES = 1 << MEM_LINES_LOG;
  localparam int SB_W  = $clog2(STALL_BURST + 1) + 1;
  localparam int SI_W  = $clog2(STALL_IDLE + 1) + 1;

  typedef enum logic [1:0] {IDLE, WBURST, RBURST} state_t;

  state_t                   state, state_nxt;
  logic [MEM_LINES_LOG-1:0] wr_ptr, rd_ptr, wr_idx, rd_idx, req_idx;
  logic [2:0]               wb_left, rb_left, size_n;
  logic [SB_W-1:0]          stall_cnt;
  logic [SI_W-1:0]          idle_cnt;
  logic                     stall, acc_wr, acc_rd, accept, rd_issue;
  logic [LINE_WIDTH-1:0]    mem [LINES];
  logic                     rd_vld_p [READ_LATENCY];
  logic [LINE_WIDTH-1:0]    rd_dat_p [READ_LATENCY];
  logic                     unused_addr_hi;

  assign unused_addr_hi = ^avl_addr[ADDR_WIDTH-1:MEM_LINES_LOG];
  assign size_n         = (avl_size == 3'd0) ? 3'd1 : avl_size;
  assign req_idx        = avl_addr[MEM_LINES_LOG-1:0];
  assign stall          = (STALL_BURST != 0) && (stall_cnt == SB_W'(STALL_BURST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (acc_wr) begin
          if (avl_burstbegin && size_n > 3'd1) state_nxt = WBURST;
        end else if (acc_rd && size_n > 3'd1) begin
          state_nxt = RBURST;
        end
      end
      WBURST: begin
        if (acc_wr) begin
          if (avl_burstbegin)         state_nxt = (size_n > 3'd1) ? WBURST : IDLE;
          else if (wb_left == 3'd1)   state_nxt = IDLE;
        end
      end
      RBURST:  if (rb_left == 3'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready depends only on registered state; the request inputs merely qualify it.
  always_comb begin
    avl_ready = (state != RBURST) && !stall;
    acc_wr    = avl_write_req && avl_ready;
    acc_rd    = avl_read_req && !avl_write_req && avl_ready && (state == IDLE);
    accept    = acc_wr || acc_rd;
    wr_idx    = (avl_burstbegin || state != WBURST) ? req_idx : wr_ptr;
    rd_issue  = acc_rd || (state == RBURST);
    rd_idx    = (state == RBURST) ? rd_ptr : req_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_left <= '0;
      rb_left <= '0;
    end else begin
      if (acc_wr && avl_burstbegin)        wb_left <= size_n - 3'd1;
      else if (acc_wr && state == WBURST)  wb_left <= wb_left - 3'd1;
      if (acc_rd)                          rb_left <= size_n - 3'd1;
      else if (state == RBURST)            rb_left <= rb_left - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_wr)   wr_ptr <= wr_idx + 1'b1;
    if (rd_issue) rd_ptr <= rd_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      idle_cnt  <= '0;
    end else if (accept) begin
      stall_cnt <= stall_cnt + SB_W'(1);
      idle_cnt  <= '0;
    end else if (int'(idle_cnt) + 1 >= STALL_IDLE) begin
      stall_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      idle_cnt  <= idle_cnt + SI_W'(1);
    end
  end

  // Storage survives reset; writes are blocked only while reset is held.
  always_ff @(posedge clk) begin
    if (acc_wr && !reset) begin
      for (int b = 0; b < BE_W; b++) begin
        if (avl_be[b]) mem[wr_idx][b*8 +: 8] <= avl_wdata[b*8 +: 8];
      end
    end
  end

  // Read pipeline: stage 0 samples memory at issue; data stages only move with a valid
  // beat, so the last stage holds the most recent returned line between beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        rd_vld_p[i] <= 1'b0;
        rd_dat_p[i] <= '0;
      end
    end else begin
      rd_vld_p[0] <= rd_issue;
      if (rd_issue) rd_dat_p[0] <= mem[rd_idx];
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_vld_p[i] <= rd_vld_p[i-1];
        if (rd_vld_p[i-1]) rd_dat_p[i] <= rd_dat_p[i-1];
      end
    end
  end

  assign avl_rdata_valid = rd_vld_p[READ_LATENCY-1];
  assign avl_rdata       = rd_dat_p[READ_LATENCY-1];

endmodule

// File: tb/tb_avl_line_responder.sv
// Bench for avl_line_responder: transaction-level model with per-cycle compare,
// plus directed scenarios with literal expectations.
module tb_avl_line_responder;

  localparam int L  = 4;
  localparam int SB = 5;
  localparam int SI = 15;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         avl_ready;
  logic [31:0]  avl_addr = '0;
  logic [2:0]   avl_size = '0;
  logic [255:0] avl_wdata = '0;
  logic [31:0]  avl_be = '0;
  logic         avl_write_req = 1'b0;
  logic         avl_read_req = 1'b0;
  logic         avl_burstbegin = 1'b0;
  logic [255:0] avl_rdata;
  logic         avl_rdata_valid;

  int n_vec = 0;
  int n_bad = 0;

  avl_line_responder dut (
    .clk(clk), .reset(reset), .avl_ready(avl_ready), .avl_addr(avl_addr),
    .avl_size(avl_size), .avl_wdata(avl_wdata), .avl_be(avl_be),
    .avl_write_req(avl_write_req), .avl_read_req(avl_read_req),
    .avl_burstbegin(avl_burstbegin), .avl_rdata(avl_rdata),
    .avl_rdata_valid(avl_rdata_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction-level model: line array, queue of scheduled returns, burst and stall bookkeeping.
  typedef struct { int due; logic [255:0] d; } rbeat_t;
  rbeat_t       q[$];
  logic [255:0] mm [64];
  int           cyc = 0, m_acc = 0, m_idle = 0, m_rb_end = 0, m_wb_left = 0;
  int           m_base = 0, m_k = 0, mn, ma;
  bit           mw, mr;
  bit           m_ready = 1'b1, exp_valid = 1'b0;
  logic [255:0] exp_rdata = '0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
      m_acc = 0; m_idle = 0; m_rb_end = 0; m_wb_left = 0;
      exp_valid = 1'b0; exp_rdata = '0; m_ready = 1'b1;
    end else begin
      mw = avl_write_req && m_ready;
      mr = avl_read_req && !avl_write_req && m_ready && (m_wb_left == 0);
      mn = (avl_size == 3'd0) ? 1 : int'(avl_size);
      if (mr) begin
        for (int i = 0; i < mn; i++) q.push_back('{cyc + L - 1 + i, mm[(int'(avl_addr) + i) % 64]});
        m_rb_end = cyc + mn - 1;
      end
      if (mw) begin
        if (avl_burstbegin) begin
          ma = int'(avl_addr); m_base = ma; m_k = 1; m_wb_left = mn - 1;
        end else if (m_wb_left > 0) begin
          ma = m_base + m_k; m_k++; m_wb_left--;
        end else begin
          ma = int'(avl_addr);
        end
        for (int b = 0; b < 32; b++)
          if (avl_be[b]) mm[ma % 64][b*8 +: 8] = avl_wdata[b*8 +: 8];
      end
      if (mw || mr) begin
        m_acc++; m_idle = 0;
      end else if (m_idle + 1 >= SI) begin
        m_idle = 0; m_acc = 0;
      end else begin
        m_idle++;
      end
      exp_valid = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_valid = 1'b1;
        exp_rdata = q[0].d;
        void'(q.pop_front());
      end
      m_ready = !(cyc < m_rb_end) && (m_acc != SB);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_ready", 256'(avl_ready), 256'(m_ready));
      chk("model_rvalid", 256'(avl_rdata_valid), 256'(exp_valid));
      chk("model_rdata", avl_rdata, exp_rdata);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input bit w, input bit r, input int addr, input logic [2:0] sz,
                       input logic [255:0] d, input logic [31:0] be, input bit bb);
    avl_write_req = w; avl_read_req = r; avl_addr = 32'(addr); avl_size = sz;
    avl_wdata = d; avl_be = be; avl_burstbegin = bb;
  endtask

  task automatic quiet();
    avl_write_req = 1'b0; avl_read_req = 1'b0; avl_burstbegin = 1'b0;
  endtask

  task automatic idle(input int n);
    quiet();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rd_check(input string nm, input int addr, input logic [255:0] exp);
    int k;
    k = 0;
    quiet();
    while (!avl_ready && k < 40) begin step(); k++; end
    if (!avl_ready) chk({nm, "_rdy_wait"}, 256'(avl_ready), 256'(1));
    drive(1'b0, 1'b1, addr, 3'd1, '0, '0, 1'b0);
    step();
    quiet();
    k = 1;
    while (!avl_rdata_valid && k < 20) begin step(); k++; end
    chk({nm, "_latency"}, 256'(k), 256'(L));
    chk({nm, "_data"}, avl_rdata, exp);
  endtask

  initial begin
    int k, nv;
    step(); step();
    chk("rst_ready", 256'(avl_ready), 256'(1));
    chk("rst_rvalid", 256'(avl_rdata_valid), 256'(0));
    chk("rst_rdata", avl_rdata, 256'(0));
    reset = 1'b0;
    idle(2);

    // Single write then read back.
    drive(1'b1, 1'b0, 3, 3'd1, {32{8'hA5}}, 32'hFFFF_FFFF, 1'b0); step();
    idle(2);
    rd_check("single", 3, {32{8'hA5}});

    // Partial write of the low word only.
    idle(16);
    drive(1'b1, 1'b0, 3, 3'd1, 256'h1122_3344, 32'h0000_000F, 1'b0); step();
    idle(2);
    rd_check("partial", 3, {{28{8'hA5}}, 32'h1122_3344});

    // Burst write wrapping past the top of memory, then burst read.
    idle(16);
    drive(1'b1, 1'b0, 62, 3'd4, 256'd1, 32'hFFFF_FFFF, 1'b1); step();
    drive(1'b1, 1'b0, 7,  3'd4, 256'd2, 32'hFFFF_FFFF, 1'b0); step();
    drive(1'b1, 1'b0, 7,  3'd4, 256'd3, 32'hFFFF_FFFF, 1'b0); step();
    drive(1'b1, 1'b0, 7,  3'd4, 256'd4, 32'hFFFF_FFFF, 1'b0); step();
    idle(16);
    drive(1'b0, 1'b1, 62, 3'd4, '0, '0, 1'b0); step(); quiet();
    chk("brd_rdy1", 256'(avl_ready), 256'(0)); step();
    chk("brd_rdy2", 256'(avl_ready), 256'(0)); step();
    chk("brd_rdy3", 256'(avl_ready), 256'(0)); step();
    chk("brd_rdy4", 256'(avl_ready), 256'(1));
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("brd_vld%0d", i), 256'(avl_rdata_valid), 256'(1));
      chk($sformatf("brd_dat%0d", i), avl_rdata, 256'(i));
      step();
    end
    chk("brd_vld_end", 256'(avl_rdata_valid), 256'(0));
    chk("brd_hold", avl_rdata, 256'd4);

    // Stall injection after five back-to-back accepts.
    idle(16);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 10 + i, 3'd1, 256'(32'h100 + i), 32'hFFFF_FFFF, 1'b0); step();
    end
    quiet();
    chk("stall_low", 256'(avl_ready), 256'(0));
    k = 0;
    while (!avl_ready && k < 40) begin step(); k++; end
    chk("stall_idle_cycles", 256'(k), 256'(SI));

    // Simultaneous read and write: write wins, no read data follows.
    idle(16);
    drive(1'b1, 1'b1, 20, 3'd1, 256'hBEEF, 32'hFFFF_FFFF, 1'b0); step(); quiet();
    nv = 0;
    for (int i = 0; i < 8; i++) begin nv += int'(avl_rdata_valid); step(); end
    chk("simul_no_rvalid", 256'(nv), 256'(0));
    rd_check("simul_wr", 20, 256'hBEEF);

    // Reset two cycles into a four-beat read.
    idle(16);
    drive(1'b0, 1'b1, 62, 3'd4, '0, '0, 1'b0); step(); quiet(); step();
    reset = 1'b1;
    #1;
    chk("midrst_rvalid", 256'(avl_rdata_valid), 256'(0));
    chk("midrst_ready", 256'(avl_ready), 256'(1));
    step();
    reset = 1'b0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin step(); nv += int'(avl_rdata_valid); end
    chk("postrst_no_rvalid", 256'(nv), 256'(0));
    chk("postrst_ready", 256'(avl_ready), 256'(1));
    rd_check("postrst_keep", 62, 256'd1);

    // Read ignored inside a write burst, burst abandoned by a new burstbegin, size 0.
    idle(16);
    drive(1'b1, 1'b0, 40, 3'd4, 256'h40, 32'hFFFF_FFFF, 1'b1); step();
    drive(1'b0, 1'b1, 50, 3'd1, '0, '0, 1'b0); step();
    drive(1'b1, 1'b0, 44, 3'd2, 256'h44, 32'hFFFF_FFFF, 1'b1); step();
    drive(1'b1, 1'b0, 9,  3'd2, 256'h45, 32'hFFFF_FFFF, 1'b0); step();
    drive(1'b1, 1'b0, 46, 3'd0, 256'h46, 32'hFFFF_FFFF, 1'b0); step();
    nv = 0;
    for (int i = 0; i < 16; i++) begin nv += int'(avl_rdata_valid); step(); end
    chk("wb_read_ignored", 256'(nv), 256'(0));
    rd_check("abandon_44", 44, 256'h44);
    rd_check("abandon_45", 45, 256'h45);
    rd_check("abandon_40", 40, 256'h40);
    rd_check("single_46", 46, 256'h46);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
